aud_i2s_player: RTL and testbench
=================================

# aud_i2s_player

Downstream stage of the audio DSP. Takes the 16-bit signed sample the DSP presents on its DAC-data output, together with the DSP's player-enable, and serialises it MSB-first onto the codec's DACDAT pin in I2S format. Frames are aligned to the codec-supplied DACLRCK. The block runs in the codec bit-clock domain (i_clk = BCLK). It contains a frame state machine, an edge detector and a shift register.

## Interface
- DATA_W, 16: sample width in bits.
- STEREO, 1: 1 replays the latched mono sample on the right channel; 0 drives zeros on the right channel.

- i_clk, in, 1: bit clock (codec BCLK); all logic on rising edge.
- i_rst, in, 1: reset, asynchronous and active-high.
- i_en, in, 1: player enable from the DSP (its o_audplayer_en), level.
- i_daclrck, in, 1: codec left/right clock (low = left channel).
- i_dac_data, in, DATA_W: sample from the DSP (its o_dac_data).
- o_aud_dacdat, out, 1: serial data to codec.
- o_busy, out, 1: high while a word is being shifted.
- o_sample_ack, out, 1: one-cycle pulse when i_dac_data is latched.

## Operation
- i_daclrck is registered into lrck_q every cycle.
  - Fall event: lrck_q=1 and i_daclrck=0.
  - Rise event: lrck_q=0 and i_daclrck=1.
- States: IDLE, SHIFT_L, WAIT_R, SHIFT_R, WAIT_L.
- IDLE / WAIT_L, on fall event:
  - If i_en=1: latch i_dac_data into sample_reg and into the shift register, pulse o_sample_ack, go to SHIFT_L.
  - If i_en=0: stay (WAIT_L→WAIT_L, IDLE→IDLE) and drive 0.
- SHIFT_L: emits bits DATA_W-1 down to 0, then goes to WAIT_R.
- WAIT_R, on rise event:
  - If STEREO=1: reload the shift register from sample_reg and go to SHIFT_R.
  - If STEREO=0: go straight to WAIT_L and drive 0 for the whole right half.
- SHIFT_R: emits DATA_W bits, then goes to WAIT_L.
- i_en falling mid-word: the current word completes. The next fall event with i_en=0 sends zeros.
- Early LRCK edge, i.e. an edge arriving while a word is still shifting:
  - The current word is abandoned.
  - The edge is handled as if the state were WAIT_L (fall event) or WAIT_R (rise event).
- Rise event seen in IDLE or WAIT_L: ignored. Playback always starts on a left channel.
- Samples are shifted unmodified (two's complement). No rounding or width change.

## Timing
- Reset values:
  - o_aud_dacdat=0, o_busy=0, o_sample_ack=0.
  - State IDLE, lrck_q=0, sample_reg=0, shift register=0, bit counter=0.
- Event detected at rising edge k:
  - o_aud_dacdat takes the MSB at edge k.
  - The codec samples the MSB at edge k+1, which is the I2S one-bit delay after the LRCK transition.
- Bit i (MSB = DATA_W-1) is driven from edge k+(DATA_W-1-i).
- After the LSB, output returns to 0 from edge k+DATA_W until the next event.
- o_busy is high from edge k through edge k+DATA_W-1.
- o_sample_ack is high for exactly the cycle following edge k (left events only).
- i_dac_data is sampled only at left-event edges, so upstream may change it at any other time.
- Minimum half-frame length is DATA_W+1 BCLK cycles. Shorter half-frames trigger the early-edge rule.
- Asserting i_rst mid-word forces all outputs to reset values immediately. After release, the block waits in IDLE for a fall event.

## Structure
- Shared package aud_pkg:
  - State enum aud_player_state_t.
  - Constant AUD_DATA_W = 16.
- One sub-module, aud_serializer:
  - Parallel-load shift register with bit counter.
  - Ports: load, data, shift-enable, serial out, done.
- FSM and edge detection live in the top module.

## Test plan
- STEREO=1, i_en=1, i_dac_data=16'hC003, LRCK half-period 20 BCLK → left bits 1100_0000_0000_0011 starting one BCLK after the fall, same 16 bits after the rise, then zeros; o_sample_ack pulses once per frame.
- i_en=0 at the fall, data=16'h0C00 → o_aud_dacdat stays 0 for the whole frame, no o_sample_ack.
- STEREO=0, data=16'h3000 → left half correct, right half all zeros.
- Rise event arrives 10 BCLK after a fall while shifting 16'hFFFF → left word truncated after 10 ones, right word restarts from the MSB.
- i_rst pulsed at bit 7 of 16'hAAAA → o_aud_dacdat, o_busy go 0 asynchronously; no output until the next fall event, which starts a fresh word.
- i_en dropped at bit 3 of 16'h000F → word completes (LSBs 1111 present); next frame is zeros.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared types and constants for the audio player path.
// Holds the player FSM state encoding and the default sample width.
package aud_pkg;

    localparam int AUD_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_L,
        ST_WAIT_R,
        ST_SHIFT_R,
        ST_WAIT_L
    } aud_player_state_t;

endpackage

// File: rtl/aud_serializer.sv
// Parallel-load, MSB-first shift register with a bit counter.
// o_done flags that the bit currently on o_sdo is the last one of the word.
module aud_serializer
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_shift_en,
    output logic              o_sdo,
    output logic              o_done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;

    // Load a word (counter set to bits remaining) or shift one bit out per cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= LAST;
        end else if (i_shift_en) begin
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_sdo  = r_shift[DATA_W-1];
    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/aud_i2s_player.sv
// I2S transmitter: frames the DSP sample onto DACDAT, aligned to DACLRCK.
// Runs entirely in the BCLK domain; LRCK edges start each channel word.
module aud_i2s_player
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W,
    parameter int STEREO = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_daclrck,
    input  logic [DATA_W-1:0] i_dac_data,
    output logic              o_aud_dacdat,
    output logic              o_busy,
    output logic              o_sample_ack
);

    localparam logic STEREO_ON = (STEREO != 0);

    aud_player_state_t r_state;
    aud_player_state_t w_state_next;

    logic              r_lrck;
    logic [DATA_W-1:0] r_sample;
    logic              r_ack;
    logic              w_fall;
    logic              w_rise;
    logic              w_load_l;
    logic              w_load_r;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic              w_shifting;
    logic              w_sdo;
    logic              w_done;

    // Delay LRCK by one BCLK so its transitions can be seen as events.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lrck <= 1'b0;
        end else begin
            r_lrck <= i_daclrck;
        end
    end

    assign w_fall = r_lrck & ~i_daclrck;
    assign w_rise = ~r_lrck & i_daclrck;

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: an LRCK edge always wins over word completion, so a short
    // half-frame abandons the word in flight.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_WAIT_L: begin
                if (w_fall && i_en) begin
                    w_state_next = ST_SHIFT_L;
                end
            end
            ST_WAIT_R: begin
                if (w_rise) begin
                    w_state_next = STEREO_ON ? ST_SHIFT_R : ST_WAIT_L;
                end
            end
            ST_SHIFT_L, ST_SHIFT_R: begin
                if (w_fall) begin
                    w_state_next = i_en ? ST_SHIFT_L : ST_WAIT_L;
                end else if (w_rise) begin
                    w_state_next = STEREO_ON ? ST_SHIFT_R : ST_WAIT_L;
                end else if (w_done) begin
                    w_state_next = (r_state == ST_SHIFT_L) ? ST_WAIT_R
                                                           : ST_WAIT_L;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: left loads take the live sample, right loads replay it.
    always_comb begin
        w_shifting  = (r_state == ST_SHIFT_L) || (r_state == ST_SHIFT_R);
        w_load_l    = w_fall && i_en && (r_state != ST_WAIT_R);
        w_load_r    = w_rise && STEREO_ON &&
                      (r_state inside {ST_WAIT_R, ST_SHIFT_L, ST_SHIFT_R});
        w_load      = w_load_l || w_load_r;
        w_load_data = w_load_l ? i_dac_data : r_sample;
    end

    // Hold the left sample for the right channel and flag each latch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sample <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= w_load_l;
            if (w_load_l) begin
                r_sample <= i_dac_data;
            end
        end
    end

    aud_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_data     (w_load_data),
        .i_shift_en (w_shifting),
        .o_sdo      (w_sdo),
        .o_done     (w_done)
    );

    assign o_busy       = w_shifting;
    assign o_aud_dacdat = w_shifting & w_sdo;
    assign o_sample_ack = r_ack;

endmodule

// File: tb/tb_aud_i2s_player.sv
// Bench for aud_i2s_player: stereo and mono instances side by side,
// frame table with hand-derived words plus a per-cycle reference model.
module tb_aud_i2s_player;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          lrck;
    logic [DW-1:0] data;

    logic dat1, busy1, ack1;
    logic dat0, busy0, ack0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    aud_i2s_player #(.DATA_W(DW), .STEREO(1)) u_st (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_daclrck    (lrck),
        .i_dac_data   (data),
        .o_aud_dacdat (dat1),
        .o_busy       (busy1),
        .o_sample_ack (ack1)
    );

    aud_i2s_player #(.DATA_W(DW), .STEREO(0)) u_mo (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_daclrck    (lrck),
        .i_dac_data   (data),
        .o_aud_dacdat (dat0),
        .o_busy       (busy0),
        .o_sample_ack (ack0)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h",
                     name, $time, act, exp);
        end
    endtask

    // Reference model, index 0 = mono instance, 1 = stereo instance.
    // A word is "active" from the LRCK event that starts it; t counts the
    // BCLK edges since then, and bit DW-1-t is on the wire while t < DW.
    bit            m_prev;
    bit            m_act  [2];
    bit            m_arm  [2];
    int            m_t    [2];
    logic [DW-1:0] m_word [2];
    logic [DW-1:0] m_lat  [2];
    bit            m_ack  [2];
    bit            m_fall, m_rise;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev = 1'b0;
            for (int s = 0; s < 2; s++) begin
                m_act[s]  = 1'b0;
                m_arm[s]  = 1'b0;
                m_t[s]    = DW;
                m_word[s] = '0;
                m_lat[s]  = '0;
                m_ack[s]  = 1'b0;
            end
        end else begin
            m_fall = m_prev && !lrck;
            m_rise = !m_prev && lrck;
            m_prev = lrck;
            for (int s = 0; s < 2; s++) begin
                m_ack[s] = 1'b0;
                if (m_t[s] < DW) m_t[s]++;
                if (m_fall) begin
                    if (en) begin
                        m_word[s] = data;
                        m_lat[s]  = data;
                        m_t[s]    = 0;
                        m_act[s]  = 1'b1;
                        m_arm[s]  = 1'b1;
                        m_ack[s]  = 1'b1;
                    end else begin
                        m_act[s] = 1'b0;
                        m_arm[s] = 1'b0;
                    end
                end else if (m_rise && m_arm[s]) begin
                    m_arm[s] = 1'b0;
                    if (s == 1) begin
                        m_word[s] = m_lat[s];
                        m_t[s]    = 0;
                        m_act[s]  = 1'b1;
                    end else begin
                        m_act[s] = 1'b0;
                    end
                end
            end
        end
    end

    logic a_dat [2];
    logic a_busy[2];
    logic a_ack [2];
    assign a_dat[0]  = dat0;
    assign a_dat[1]  = dat1;
    assign a_busy[0] = busy0;
    assign a_busy[1] = busy1;
    assign a_ack[0]  = ack0;
    assign a_ack[1]  = ack1;

    // Compare every output of both instances with the model each cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int s = 0; s < 2; s++) begin
                logic eb;
                logic ed;
                eb = m_act[s] && (m_t[s] < DW);
                ed = 1'b0;
                if (eb) ed = m_word[s][DW-1-m_t[s]];
                check($sformatf("model_dat%0d", s), 32'(a_dat[s]), 32'(ed));
                check($sformatf("model_busy%0d", s), 32'(a_busy[s]), 32'(eb));
                check($sformatf("model_ack%0d", s), 32'(a_ack[s]),
                      32'(m_ack[s]));
            end
        end
    end

    // Drive one LRCK half for n cycles; capture the first DW serial bits
    // of each instance (left-aligned when the half is short).
    task automatic half(input logic lv, input int n, input int drop_at,
                        output logic [DW-1:0] w1, output logic [DW-1:0] w0,
                        output int acks);
        lrck = lv;
        w1   = '0;
        w0   = '0;
        acks = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (j < DW) begin
                w1 = {w1[DW-2:0], dat1};
                w0 = {w0[DW-2:0], dat0};
            end
            acks += int'(ack1);
            if (j == drop_at) en = 1'b0;
        end
        if (n < DW) begin
            w1 = w1 << (DW - n);
            w0 = w0 << (DW - n);
        end
    endtask

    typedef struct {
        logic          en;
        logic [DW-1:0] data;
        int            hl;
        int            hr;
        int            drop;
        logic [DW-1:0] el;
        logic [DW-1:0] er1;
        logic [DW-1:0] er0;
        int            eack;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [DW-1:0] w1, w0, r1, r0;
        int a1, a2;

        vt[0] = '{1'b1, 16'hC003, 20, 20, -1, 16'hC003, 16'hC003, 16'h0000, 1};
        vt[1] = '{1'b0, 16'h0C00, 20, 20, -1, 16'h0000, 16'h0000, 16'h0000, 0};
        vt[2] = '{1'b1, 16'h3000, 20, 20, -1, 16'h3000, 16'h3000, 16'h0000, 1};
        vt[3] = '{1'b1, 16'hFFFF, 10, 20, -1, 16'hFFC0, 16'hFFFF, 16'h0000, 1};
        vt[4] = '{1'b1, 16'h000F, 20, 20, 12, 16'h000F, 16'h000F, 16'h0000, 1};
        vt[5] = '{1'b0, 16'h000F, 20, 20, -1, 16'h0000, 16'h0000, 16'h0000, 0};
        vt[6] = '{1'b1, 16'h8001, 17, 17, -1, 16'h8001, 16'h8001, 16'h0000, 1};
        vt[7] = '{1'b1, 16'h1234, 24, 16, -1, 16'h1234, 16'h1234, 16'h0000, 1};

        rst  = 1'b1;
        en   = 1'b0;
        lrck = 1'b0;
        data = '0;
        repeat (3) @(negedge clk);
        check("rst_dat1", 32'(dat1), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_dat0", 32'(dat0), 32'd0);
        chk_on = 1'b1;
        rst    = 1'b0;
        en     = 1'b1;
        lrck   = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_rise_busy", 32'(busy1), 32'd0);

        for (int i = 0; i < 8; i++) begin
            en   = vt[i].en;
            data = vt[i].data;
            half(1'b0, vt[i].hl, vt[i].drop, w1, w0, a1);
            half(1'b1, vt[i].hr, -1, r1, r0, a2);
            check($sformatf("v%0d_left_st", i), 32'(w1), 32'(vt[i].el));
            check($sformatf("v%0d_left_mo", i), 32'(w0), 32'(vt[i].el));
            check($sformatf("v%0d_right_st", i), 32'(r1), 32'(vt[i].er1));
            check($sformatf("v%0d_right_mo", i), 32'(r0), 32'(vt[i].er0));
            check($sformatf("v%0d_acks", i), 32'(a1 + a2), 32'(vt[i].eack));
        end

        en   = 1'b1;
        data = 16'hAAAA;
        lrck = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("pre_rst_dat", 32'(dat1), 32'd1);
        check("pre_rst_busy", 32'(busy1), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_dat1", 32'(dat1), 32'd0);
        check("async_rst_busy1", 32'(busy1), 32'd0);
        check("async_rst_dat0", 32'(dat0), 32'd0);
        check("async_rst_busy0", 32'(busy0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        half(1'b0, 10, -1, w1, w0, a1);
        check("post_rst_low", 32'(w1), 32'd0);
        half(1'b1, 20, -1, w1, w0, a1);
        check("post_rst_rise_ign", 32'(w1), 32'd0);
        check("post_rst_acks", 32'(a1), 32'd0);
        half(1'b0, 20, -1, w1, w0, a1);
        half(1'b1, 20, -1, r1, r0, a2);
        check("fresh_left", 32'(w1), 32'hAAAA);
        check("fresh_right_st", 32'(r1), 32'hAAAA);
        check("fresh_right_mo", 32'(r0), 32'h0000);
        check("fresh_acks", 32'(a1 + a2), 32'd1);

        for (int f = 0; f < 40; f++) begin
            for (int h = 0; h < 2; h++) begin
                int n;
                n    = int'($urandom_range(8, 24));
                lrck = (h == 1);
                for (int c = 0; c < n; c++) begin
                    data = DW'($urandom);
                    if ($urandom_range(0, 15) == 0) en = ~en;
                    @(negedge clk);
                end
            end
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
